// File: rtl/algofoogle_product_mac_if.sv
// Host-side bundle for the serial MAC: nibble input stream plus the result byte stream and status.
interface algofoogle_product_mac_if;
  logic [3:0] nibble;
  logic       in_valid;
  logic       signed_mode;
  logic       acc_mode;
  logic       clear_acc;
  logic [7:0] byte_out;
  logic       out_valid;
  logic       busy;
  logic       overflow;

  modport master (
    output nibble, in_valid, signed_mode, acc_mode, clear_acc,
    input  byte_out, out_valid, busy, overflow
  );

  modport slave (
    input  nibble, in_valid, signed_mode, acc_mode, clear_acc,
    output byte_out, out_valid, busy, overflow
  );
endinterface

// File: rtl/algofoogle_product_mac.sv
// Nibble-serial signed/unsigned multiply-accumulate with a guarded, persistent accumulator
// streamed out MSB byte first.
module algofoogle_product_mac #(
  parameter int unsigned OP_NIBBLES  = 3,
  parameter int unsigned GUARD_BYTES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  algofoogle_product_mac_if.slave   bus
);
  localparam int unsigned OP_BITS   = 4 * OP_NIBBLES;
  localparam int unsigned MUL_BITS  = 2 * OP_BITS;
  localparam int unsigned ACC_BITS  = MUL_BITS + 8 * GUARD_BYTES;
  localparam int unsigned OUT_BYTES = ACC_BITS / 8;
  localparam int unsigned NIBS      = 2 * OP_NIBBLES;
  localparam int unsigned CNT_MAX   = (NIBS > OUT_BYTES) ? NIBS : OUT_BYTES;
  localparam int unsigned CW        = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] LAST_NIB  = CW'(NIBS - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(OUT_BYTES - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_CALC,
    S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [MUL_BITS-1:0]   opnd_q, opnd_d;
  logic                  sgn_q, sgn_d;
  logic                  accm_q, accm_d;
  logic [ACC_BITS-1:0]   acc_q, acc_d;
  logic [ACC_BITS-1:0]   sh_q, sh_d;
  logic                  ovf_q, ovf_d;

  logic [OP_BITS-1:0]    a_w, b_w;
  logic [ACC_BITS-1:0]   a_ext, b_ext, prod, base;
  logic [ACC_BITS:0]     sum;
  logic                  ovf_ev;

  assign a_w = opnd_q[MUL_BITS-1:OP_BITS];
  assign b_w = opnd_q[OP_BITS-1:0];

  // Operands are extended to full accumulator width before multiplying, so the truncated
  // product is already the correctly sign- or zero-extended result.
  always_comb begin
    a_ext  = {{(ACC_BITS-OP_BITS){sgn_q & a_w[OP_BITS-1]}}, a_w};
    b_ext  = {{(ACC_BITS-OP_BITS){sgn_q & b_w[OP_BITS-1]}}, b_w};
    prod   = a_ext * b_ext;
    base   = bus.clear_acc ? '0 : acc_q;
    sum    = {1'b0, base} + {1'b0, prod};
    ovf_ev = accm_q & (sgn_q ? ((base[ACC_BITS-1] == prod[ACC_BITS-1]) &&
                                (sum[ACC_BITS-1] != base[ACC_BITS-1]))
                             : sum[ACC_BITS]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    sgn_d   = sgn_q;
    accm_d  = accm_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_LOAD: begin
        if (bus.clear_acc) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (bus.in_valid) begin
          opnd_d = {opnd_q[MUL_BITS-5:0], bus.nibble};
          if (cnt_q == '0) begin
            sgn_d  = bus.signed_mode;
            accm_d = bus.acc_mode;
          end
          if (cnt_q == LAST_NIB) begin
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CALC: begin
        acc_d   = accm_q ? sum[ACC_BITS-1:0] : prod;
        ovf_d   = (accm_q & ~bus.clear_acc & ovf_q) | ovf_ev;
        sh_d    = acc_d;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.clear_acc) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        sh_d = {sh_q[ACC_BITS-9:0], 8'h00};
        if (cnt_q == LAST_BYTE) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      opnd_q  <= '0;
      sgn_q   <= 1'b0;
      accm_q  <= 1'b0;
      acc_q   <= '0;
      sh_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      sgn_q   <= sgn_d;
      accm_q  <= accm_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_valid = (state_q == S_OUT);
  assign bus.busy      = (state_q != S_LOAD);
  assign bus.byte_out  = (state_q == S_OUT) ? sh_q[ACC_BITS-1 -: 8] : '0;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_algofoogle_product_mac.sv
// Self-checking bench for algofoogle_product_mac with default parameters (12-bit operands, 32-bit accumulator).
module tb_algofoogle_product_mac;
  localparam longint TWO31 = 64'sd2147483648;
  localparam longint TWO32 = 64'sd4294967296;

  logic clk;
  logic reset;
  algofoogle_product_mac_if bus ();

  algofoogle_product_mac #(.OP_NIBBLES(3), .GUARD_BYTES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_acc;
  bit          m_ovf;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    bit          sgn;
    bit          accm;
    bit          clr;
    logic [31:0] want;
    bit          ovf;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic longint sx12(input logic [11:0] v);
    return v[11] ? longint'(v) - 4096 : longint'(v);
  endfunction

  // Reference: exact integer product, then accumulate with range-based overflow detection.
  task automatic model_calc(input logic [11:0] a, input logic [11:0] b, input bit sgn,
                            input bit accm, input bit clr, output logic [31:0] res);
    longint p, base, s;
    bit ev;
    p    = sgn ? sx12(a) * sx12(b) : longint'(a) * longint'(b);
    base = clr ? 0 : longint'(m_acc);
    ev   = 1'b0;
    if (accm) begin
      if (sgn) begin
        s  = ((base >= TWO31) ? base - TWO32 : base) + p;
        ev = (s >= TWO31) || (s < -TWO31);
      end else begin
        s  = base + p;
        ev = (s >= TWO32);
      end
      res = 32'(base + p);
    end else begin
      res = 32'(p);
    end
    m_ovf = (accm && !clr) ? (m_ovf | ev) : ev;
    m_acc = res;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.clear_acc = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_byte_out", bus.byte_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overflow", bus.overflow, 0);
    reset = 1'b0;
    m_acc = '0;
    m_ovf = 1'b0;
  endtask

  task automatic send_operands(input logic [11:0] a, input logic [11:0] b,
                               input bit sgn, input bit accm, input bit stall);
    logic [23:0] ops;
    ops = {a, b};
    for (int i = 0; i < 6; i++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.nibble   = 4'($urandom);
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.nibble   = ops[23-4*i -: 4];
      if (i == 0) begin
        bus.signed_mode = sgn;
        bus.acc_mode    = accm;
      end else if (stall) begin
        bus.signed_mode = 1'($urandom);
        bus.acc_mode    = 1'($urandom);
      end
    end
  endtask

  task automatic run_txn(input logic [11:0] a, input logic [11:0] b, input bit sgn,
                         input bit accm, input bit clr_calc, input bit clr_out, input bit stall,
                         output logic [31:0] got, output bit got_ovf);
    logic [31:0] want;
    send_operands(a, b, sgn, accm, stall);
    @(negedge clk);
    check("calc_busy", bus.busy, 1);
    check("calc_out_valid", bus.out_valid, 0);
    bus.in_valid  = stall;
    bus.nibble    = 4'($urandom);
    bus.clear_acc = clr_calc;
    model_calc(a, b, sgn, accm, clr_calc, want);
    got = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        check("out_valid", bus.out_valid, 1);
        got = {got[23:0], bus.byte_out};
      end else begin
        check("done_out_valid", bus.out_valid, 0);
        check("done_busy", bus.busy, 0);
        check("idle_byte_out", bus.byte_out, 0);
        check("overflow", bus.overflow, m_ovf);
      end
      bus.clear_acc = clr_out && (k == 1);
      if (clr_out && k == 1) begin
        m_acc = '0;
        m_ovf = 1'b0;
      end
      bus.in_valid = (stall && k < 4) ? 1'($urandom) : 1'b0;
      bus.nibble   = 4'($urandom);
    end
    check("result_bytes", got, want);
    got_ovf = bus.overflow;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    bit          gov;
    logic [11:0] ra, rb;

    reset           = 1'b1;
    bus.nibble      = '0;
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    bus.acc_mode    = 1'b0;
    bus.clear_acc   = 1'b0;
    m_acc           = '0;
    m_ovf           = 1'b0;

    tbl[0] = '{12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b0, 32'h00FFE001, 1'b0};
    tbl[1] = '{12'hFFF, 12'h002, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0};
    tbl[2] = '{12'h800, 12'h7FF, 1'b1, 1'b1, 1'b1, 32'hFFC00800, 1'b0};
    tbl[3] = '{12'h123, 12'h010, 1'b0, 1'b0, 1'b0, 32'h00001230, 1'b0};
    tbl[4] = '{12'h001, 12'h001, 1'b0, 1'b1, 1'b0, 32'h00001231, 1'b0};
    tbl[5] = '{12'h001, 12'h001, 1'b0, 1'b1, 1'b1, 32'h00000001, 1'b0};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].accm, tbl[i].clr, 1'b0, 1'b0, got, gov);
      check("tbl_bytes", got, tbl[i].want);
      check("tbl_overflow", gov, tbl[i].ovf);
    end

    // Stalled loading with busy-time noise must match the clean result.
    run_txn(12'h123, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, got, gov);
    check("stall_bytes", got, 32'h00001230);

    // Unsigned accumulation walking into a carry out of the top bit.
    do_reset();
    for (int n = 1; n <= 257; n++) begin
      run_txn(12'hFFF, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, got, gov);
      if (n == 256) begin
        check("acc256_bytes", got, 32'hFFE00100);
        check("acc256_overflow", gov, 0);
      end else if (n == 257) begin
        check("acc257_bytes", got, 32'h00DFE101);
        check("acc257_overflow", gov, 1);
      end
    end
    run_txn(12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, got, gov);
    check("replace_clears_overflow", gov, 0);
    check("replace_bytes", got, 32'h00FFE001);

    // Reset in the middle of an output stream.
    send_operands(12'h123, 12'h010, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_byte0", bus.byte_out, 8'h00);
    @(negedge clk);
    check("mid_valid1", bus.out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_byte_out", bus.byte_out, 0);
    reset = 1'b0;
    m_acc = '0;
    m_ovf = 1'b0;
    run_txn(12'h001, 12'h001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, got, gov);
    check("post_rst_bytes", got, 32'h00000001);

    // Randomized traffic against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.clear_acc = 1'b1;
        @(negedge clk);
        bus.clear_acc = 1'b0;
        m_acc = '0;
        m_ovf = 1'b0;
      end
      ra = 12'($urandom);
      rb = 12'($urandom);
      run_txn(ra, rb, 1'($urandom), 1'($urandom_range(0, 3) != 0),
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'($urandom), got, gov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
